xor_stream_decoder: RTL
=======================

# xor_stream_decoder

Receive-side XOR stream decipher for the data path. Words enciphered upstream by XORing with a 16-bit Galois LFSR keystream are recovered by XORing each accepted word with the same keystream, regenerated locally from a shared seed. The block sits between the link input and the consumer. Both sides use valid/ready handshakes. Output is registered, giving one word of buffering.

## Interface
Parameters:
- SIZE, default 8: data word width; legal range 1..16.
- DEFAULT_SEED, default 16'hACE1: substituted whenever a zero seed is loaded.

Ports:
- clk, input, 1: the only clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- seed_load, input, 1: load the value on seed and (re)start the stream.
- seed, input, 16: keystream seed.
- in_valid, input, 1: the in_data word is valid.
- in_ready, output, 1: the block accepts in_data this cycle.
- in_data, input, SIZE: enciphered word.
- out_valid, output, 1: out_data holds a deciphered word.
- out_ready, input, 1: the consumer accepts out_data this cycle.
- out_data, output, SIZE: deciphered word.
- seeded, output, 1: the state is RUN.
- word_count, output, 16: words accepted since the last seed load; wraps at 16'hFFFF -> 0.

## Operation
- States:
  - UNSEEDED: entered on reset.
  - RUN: entered from any state on seed_load.
  - There is no other exit from RUN; only reset returns to UNSEEDED.
- LFSR, 16 bits, Galois, right-shift: next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000).
- Seed load:
  - The LFSR takes seed, or DEFAULT_SEED if seed == 0. The LFSR is never zero.
  - word_count is cleared to 0.
  - out_valid is cleared, so any pending output word is discarded.
  - in_ready is 0 in the seed_load cycle.
- Key for the current word: k = lfsr[SIZE-1:0].
- Accept:
  - Condition: in_valid && in_ready.
  - in_ready = seeded && !seed_load && (!out_valid || out_ready).
  - On accept: out_data <= in_data ^ k, out_valid <= 1, the LFSR advances one step, and word_count increments.
- Output handshake:
  - When out_valid && out_ready with no accept in the same cycle, out_valid <= 0.
  - When both happen in the same cycle, the new word replaces the old one and out_valid stays 1. This gives full throughput.
- Stall: while out_valid && !out_ready, out_data, LFSR and word_count hold, and in_ready is 0.
- In UNSEEDED: in_ready = 0, out_valid = 0, and in_data is ignored.
- The encoder is the same datapath. Decode(encode(x)) == x when the same seed is used and word order is kept.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state UNSEEDED, seeded 0, lfsr DEFAULT_SEED, out_valid 0, out_data 0, word_count 0, in_ready 0.
- Reset can be asserted mid-transfer. The in-flight output word is lost, with no partial update.
- seeded becomes 1 on the edge that samples seed_load. in_ready can be 1 from the following cycle.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N. Throughput is one word per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready. out_data and out_valid are purely registered.
- seed_load and an accept can never occur together, because in_ready is forced to 0. seed_load with out_ready high in the same cycle still discards the word.
- word_count wrap: the 65536th accept after a seed load reads 0.

## Test plan
- Reset with rst_n low -> all outputs at their reset values and in_ready 0, even with in_valid 1.
- Stream 0xAA, 0x4B, 0x00:
  - Setup: SIZE=8, seed_load with seed 16'hACE1, out_ready 1.
  - Required outputs: 0x4B, 0x3B, 0x38 (keys E1, 70, 38).
  - Required word_count: 3.
- Zero seed: seed_load with seed 0 -> same output sequence as with seed 16'hACE1.
- Backpressure:
  - Hold out_ready 0 for 3 cycles after the first word -> in_ready 0, and out_data holds 0x4B.
  - Release out_ready -> the second word 0x3B follows with no keystream skip.
- Reseed mid-stream while out_valid = 1 -> out_valid drops, word_count reads 0, and the next 0xAA yields 0x4B again.
- Round trip: 300 random words through an encoder instance and this block with the same seed -> outputs equal inputs, word_count 300.
  - Also preload the count near its limit and check the 0xFFFF -> 0 wrap.

Source files
------------

// File: rtl/xor_stream_decoder.sv
// xor_stream_decoder
// Receive-side XOR stream decipher. Each accepted word is XORed with the low
// SIZE bits of a 16-bit Galois LFSR keystream that is regenerated locally from
// a shared seed. The same block used upstream acts as the encoder.
//
// Control states:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   UNSEEDED  | after reset; input is blocked, no output is produced
//   RUN       | keystream live; words accepted and deciphered (exit: reset)
//
// The output stage is a single registered slot. A new word may enter in the
// same cycle the consumer takes the old one, so the stream runs at one word
// per cycle while out_ready stays high.

module xor_stream_decoder #(
  parameter int          SIZE         = 8,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            seed_load,
  input  logic [15:0]     seed,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic            seeded,
  output logic [15:0]     word_count
);

  typedef enum logic {
    ST_UNSEEDED = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  state_t            state_q,      state_d;
  logic [15:0]       lfsr_q,       lfsr_d;
  logic              out_valid_q,  out_valid_d;
  logic [SIZE-1:0]   out_data_q,   out_data_d;
  logic [15:0]       word_count_q, word_count_d;

  logic              run;
  logic              accept;
  logic              out_fire;
  logic [SIZE-1:0]   key;
  logic [15:0]       lfsr_step;
  logic [15:0]       seed_eff;

  // One right-shift step of the Galois LFSR; a nonzero state never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Handshake qualifiers and keystream taps for the current word.
  always_comb begin
    run       = (state_q == ST_RUN);
    // Seed load and accept are mutually exclusive by construction: the load
    // cycle blocks input so the keystream restart is never mixed with a word.
    in_ready  = run && !seed_load && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    out_fire  = out_valid_q && out_ready;
    key       = lfsr_q[SIZE-1:0];
    lfsr_step = lfsr_next(lfsr_q);
    // A zero seed would lock the LFSR at zero, so it is replaced.
    seed_eff  = (seed == 16'h0000) ? DEFAULT_SEED : seed;
  end

  // Next-state selection: seed load wins, then accept, then output drain.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    word_count_d = word_count_q;

    if (seed_load) begin
      // Restart from any state; a pending word is discarded even if the
      // consumer is taking it in this same cycle.
      state_d      = ST_RUN;
      lfsr_d       = seed_eff;
      word_count_d = 16'h0000;
      out_valid_d  = 1'b0;
    end else if (accept) begin
      // Replaces the held word; covers the simultaneous drain case as well.
      out_data_d   = in_data ^ key;
      out_valid_d  = 1'b1;
      lfsr_d       = lfsr_step;
      word_count_d = word_count_q + 16'h0001;
    end else if (out_fire) begin
      out_valid_d  = 1'b0;
    end
  end

  // State and registered outputs; reset drops any in-flight word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_UNSEEDED;
      lfsr_q       <= DEFAULT_SEED;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      word_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign word_count = word_count_q;
  assign seeded     = (state_q == ST_RUN);

endmodule
